// File: rtl/adc16dv160_input_common_pkg.sv
// Shared definitions for the ADC16DV160 input capture path: capture FSM states,
// ramp step and CR/SR bit positions used by the AXI-Lite register block.
package adc16dv160_input_common;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_CAPTURE = 2'd1,
        CAP_DRAIN   = 2'd2
    } cap_state_e;

    localparam int RAMP_STEP = 2;

    localparam int _CR_TEST = 1;
    localparam int _SR_PC   = 0;
    localparam int _SR_OVF  = 1;

endpackage

// File: rtl/adc16dv160_input_capture_ctrl_test_gen.sv
// Ramp test pattern source: word = {ramp+1, ramp}, ramp steps by RAMP_STEP per
// advance and is forced to zero by load_zero_i.
module adc16dv160_input_test_gen
    import adc16dv160_input_common::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_zero_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] word_o
);

    logic [15:0] ramp_q, ramp_d;
    logic [31:0] pair;

    always_comb begin
        ramp_d = ramp_q;
        if (load_zero_i) begin
            ramp_d = '0;
        end else if (advance_i) begin
            ramp_d = ramp_q + 16'(RAMP_STEP);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end

    // Channel B carries the odd value so both channels are distinguishable.
    assign pair   = {ramp_q + 16'd1, ramp_q};
    assign word_o = DATA_W'(pair);

endmodule

// File: rtl/adc16dv160_input_capture_ctrl.sv
// ADC16DV160 capture sequencer: forwards dsize sample words to an AXI4-Stream
// master with TLAST on the final word. ADC16DV160_CAPTURE_OVF_CNT_EN adds ovf_cnt.
module adc16dv160_input_capture_ctrl
    import adc16dv160_input_common::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  dsize,
    input  logic              cr_test,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              M_AXIS_TLAST,
    output logic              busy,
    output logic              sr_pc,
    output logic              ovf
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);

    cap_state_e        state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              test_q, test_d;
    logic              abort_pend_q, abort_pend_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              busy_q, busy_d;
    logic              sr_pc_q, sr_pc_d;
    logic              ovf_q, ovf_d;
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
    logic [15:0]       ovf_cnt_q, ovf_cnt_d;
`endif

    logic [DATA_W-1:0] ramp_word, sample;
    logic in_cap, hs, room, accept, drop, tag_held, start_ok, last_sample;

    assign in_cap      = (state_q == CAP_CAPTURE);
    assign hs          = tvalid_q & M_AXIS_TREADY;
    assign room        = !tvalid_q | M_AXIS_TREADY;
    assign accept      = in_cap & adc_valid & room;
    assign drop        = in_cap & adc_valid & !room;
    // A stalled word is the last one we will ever send, so abort tags it directly.
    assign tag_held    = in_cap & abort & tvalid_q & !M_AXIS_TREADY;
    assign start_ok    = (state_q == CAP_IDLE) & start;
    assign last_sample = (remaining_q == CNT_W'(1)) | abort | abort_pend_q;
    assign sample      = test_q ? ramp_word : adc_data;

    adc16dv160_input_test_gen #(
        .DATA_W (DATA_W)
    ) u_test_gen (
        .clk_i       (ACLK),
        .rst_n_i     (ARESETN),
        .load_zero_i (start_ok),
        .advance_i   (accept & test_q),
        .word_o      (ramp_word)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        test_d       = test_q;
        abort_pend_d = abort_pend_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        busy_d       = busy_q;
        sr_pc_d      = sr_pc_q;
        ovf_d        = ovf_q;
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
        ovf_cnt_d    = ovf_cnt_q;
`endif

        if (accept) begin
            tdata_d  = sample;
            tvalid_d = 1'b1;
            tlast_d  = last_sample;
        end else if (hs) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case (state_q)
            CAP_IDLE: begin
                if (start) begin
                    sr_pc_d = (dsize == '0);
                    ovf_d   = 1'b0;
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
                    ovf_cnt_d = '0;
`endif
                    if (dsize != '0) begin
                        state_d      = CAP_CAPTURE;
                        remaining_d  = dsize;
                        test_d       = cr_test;
                        abort_pend_d = 1'b0;
                        busy_d       = 1'b1;
                    end
                end
            end
            CAP_CAPTURE: begin
                if (drop) begin
                    ovf_d = 1'b1;
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
                    if (ovf_cnt_q != 16'hFFFF) begin
                        ovf_cnt_d = ovf_cnt_q + 16'd1;
                    end
`endif
                end
                if (tag_held) begin
                    tlast_d = 1'b1;
                    state_d = CAP_DRAIN;
                end else if (accept) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (last_sample) begin
                        state_d = CAP_DRAIN;
                    end
                end else if (abort) begin
                    abort_pend_d = 1'b1;
                end
            end
            CAP_DRAIN: begin
                if (hs & tlast_q) begin
                    state_d = CAP_IDLE;
                    busy_d  = 1'b0;
                    sr_pc_d = 1'b1;
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= CAP_IDLE;
            remaining_q  <= '0;
            test_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            sr_pc_q      <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
            ovf_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            test_q       <= test_d;
            abort_pend_q <= abort_pend_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            busy_q       <= busy_d;
            sr_pc_q      <= sr_pc_d;
            ovf_q        <= ovf_d;
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
            ovf_cnt_q    <= ovf_cnt_d;
`endif
        end
    end

    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign busy          = busy_q;
    assign sr_pc         = sr_pc_q;
    assign ovf           = ovf_q;
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
    assign ovf_cnt       = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_adc16dv160_input_capture_ctrl.sv
// Bench for adc16dv160_input_capture_ctrl: table-driven captures scored against a
// transaction-level queue model, plus directed abort and reset sequences.
module tb_adc16dv160_input_capture_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        start, abort, cr_test, adc_valid, tready;
    logic [31:0] dsize, adc_data, tdata;
    logic        tvalid, tlast, busy, sr_pc, ovf;
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    adc16dv160_input_capture_ctrl dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .abort         (abort),
        .dsize         (dsize),
        .cr_test       (cr_test),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .M_AXIS_TLAST  (tlast),
        .busy          (busy),
        .sr_pc         (sr_pc),
        .ovf           (ovf)
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
        ,
        .ovf_cnt       (ovf_cnt)
`endif
    );

    typedef struct {
        int          dsize;
        bit          test;
        int          vpct;
        int          rpct;
        logic [31:0] base;
        int          stall_at;
        int          stall_len;
        bit          ab_start;
        int          exp_beats;
        bit          exp_pc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: the stream is the in-order list of samples the capture takes.
    // A sample is taken while words are still owed and the single output slot is
    // free or freed by this cycle's handshake; otherwise it is lost (overflow).
    task automatic run_vec(input vec_t v);
        logic [32:0] eq[$];
        logic [32:0] w;
        logic [31:0] d, prev_data;
        logic        prev_last;
        int          pending, rem, k, drops, beats, offered;
        bit          ovfm, r, vld, prev_stall;
        pending = 0; rem = v.dsize; k = 0; drops = 0; beats = 0; offered = 0;
        ovfm = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        @(negedge ACLK);
        start = 1; dsize = v.dsize; cr_test = v.test; abort = v.ab_start;
        adc_valid = 0; tready = 1;
        @(negedge ACLK);
        start = 0; abort = 0;
        if (v.dsize != 0) check("busy_after_start", busy, 1);
        for (int cyc = 0; cyc < 600 && (rem != 0 || pending != 0); cyc++) begin
            vld = ($urandom_range(99) < v.vpct);
            r   = ($urandom_range(99) < v.rpct) &&
                  !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
            d   = (v.base != 0) ? v.base + offered : $urandom;
            adc_valid = vld; adc_data = d; tready = r;
            check("tvalid", tvalid, pending != 0);
            if (prev_stall) begin
                check("stall_tdata", tdata, prev_data);
                check("stall_tlast", tlast, prev_last);
            end
            if (tvalid && r) begin
                beats++;
                if (eq.size() > 0) begin
                    w = eq.pop_front();
                    check("beat_tdata", tdata, w[31:0]);
                    check("beat_tlast", tlast, w[32]);
                end else begin
                    check("unexpected_beat", beats, 0);
                end
            end
            prev_stall = tvalid && !r; prev_data = tdata; prev_last = tlast;
            if (pending != 0 && r) pending = 0;
            if (rem != 0 && vld) begin
                if (pending == 0) begin
                    w[32]    = (rem == 1);
                    w[31:0]  = v.test ? {16'(2 * k + 1), 16'(2 * k)} : d;
                    eq.push_back(w);
                    pending = 1; rem--; k++;
                end else begin
                    ovfm = 1; drops++;
                end
            end
            if (vld) offered++;
            @(negedge ACLK);
        end
        adc_valid = 0;
        check("completed_in_budget", (rem != 0 || pending != 0), 0);
        check("end_tvalid", tvalid, 0);
        check("end_busy", busy, 0);
        check("end_sr_pc", sr_pc, v.exp_pc);
        check("end_ovf", ovf, ovfm);
        check("beat_count", beats, v.exp_beats);
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
        check("ovf_cnt", ovf_cnt, (drops > 65535) ? 32'hFFFF : drops);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, cnt;
        bit done;
        vec_t rv;

        ARESETN = 0; start = 0; abort = 0; dsize = 0; cr_test = 0;
        adc_data = 0; adc_valid = 0; tready = 0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_sr_pc", sr_pc, 0);
        check("rst_ovf", ovf, 0);
`ifdef ADC16DV160_CAPTURE_OVF_CNT_EN
        check("rst_ovf_cnt", ovf_cnt, 0);
`endif
        ARESETN = 1;

        //           dsize test vpct rpct base       st  len ab  beats pc
        vecs[0] = '{4,    0,  100, 100, 32'h11,    0,  0,  0,  4,    1};
        vecs[1] = '{3,    1,  100, 100, 32'h0,     0,  0,  0,  3,    1};
        vecs[2] = '{1,    0,  100, 100, 32'h55,    0,  0,  0,  1,    1};
        vecs[3] = '{0,    0,  100, 100, 32'h0,     0,  0,  0,  0,    1};
        vecs[4] = '{5,    0,  100, 100, 32'h100,   2,  3,  0,  5,    1};
        vecs[5] = '{2,    1,  100, 100, 32'h0,     0,  0,  1,  2,    1};
        vecs[6] = '{12,   0,  70,  60,  32'h0,     0,  0,  0,  12,   1};
        vecs[7] = '{9,    1,  100, 30,  32'h0,     0,  0,  0,  9,    1};
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1};
            rv.dsize     = $urandom_range(1, 15);
            rv.test      = $urandom_range(0, 1);
            rv.vpct      = $urandom_range(30, 100);
            rv.rpct      = $urandom_range(20, 100);
            rv.exp_beats = rv.dsize;
            run_vec(rv);
        end

        // Abort after 10 accepted samples; a start mid-capture must be ignored.
        @(negedge ACLK);
        start = 1; dsize = 100; cr_test = 0; adc_valid = 0; tready = 1;
        @(negedge ACLK);
        start = 0; beats = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            adc_valid = 1; adc_data = i; abort = (i == 10);
            start = (i == 5); dsize = (i == 5) ? 3 : 100;
            if (tvalid) begin
                beats++;
                if (tlast) begin
                    check("abort_last_data", tdata, beats - 1);
                    done = 1;
                end
            end
            @(negedge ACLK);
        end
        abort = 0; adc_valid = 0; start = 0;
        check("abort_done", done, 1);
        check("abort_beats", beats, 11);
        check("abort_sr_pc", sr_pc, 1);
        check("abort_busy", busy, 0);
        check("abort_tvalid", tvalid, 0);

        // Abort while the held word is stalled: that word becomes the last one.
        @(negedge ACLK);
        start = 1; dsize = 10; cr_test = 0; adc_valid = 0; tready = 1;
        @(negedge ACLK);
        start = 0; adc_valid = 1; adc_data = 32'hA0; tready = 1;
        @(negedge ACLK);
        check("held_beat0", tdata, 32'hA0);
        check("held_beat0_last", tlast, 0);
        adc_data = 32'hA1;
        @(negedge ACLK);
        adc_valid = 0; tready = 0; abort = 1;
        @(negedge ACLK);
        abort = 0; tready = 1;
        check("held_tvalid", tvalid, 1);
        check("held_tdata", tdata, 32'hA1);
        check("held_tlast", tlast, 1);
        @(negedge ACLK);
        check("held_sr_pc", sr_pc, 1);
        check("held_busy", busy, 0);
        check("held_tvalid_after", tvalid, 0);

        // Reset mid-capture after 3 beats, then a fresh ramp capture.
        start = 1; dsize = 8; cr_test = 1; adc_valid = 0; tready = 1;
        @(negedge ACLK);
        start = 0; cnt = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            adc_valid = 1;
            if (tvalid) cnt++;
            if (cnt < 3) @(negedge ACLK);
        end
        check("pre_reset_beats", cnt, 3);
        ARESETN = 0;
        @(negedge ACLK);
        ARESETN = 1; adc_valid = 0;
        check("mid_rst_tvalid", tvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tlast", tlast, 0);
        rv = '{2, 1, 100, 100, 32'h0, 0, 0, 0, 2, 1};
        run_vec(rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
